// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM state
// encodings, port identifiers and default bus widths.
package mem_arb_pkg;

    localparam int DEFAULT_ADDR_W = 8;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way winner select for the data-memory arbiter.
// Build option: define MEM_ARB_FIXED_PRIO_EN to make port A win every tie
// (last_winner is then ignored and port B can starve); by default ties
// go to the port that did not win last.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       any_req,
    output logic       winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_winner;
    assign unused_last_winner = last_winner;
`endif

    // Pick the winning port from the current requests.
    // NOTE: every output of a combinational block gets a default first, so
    // no path through it leaves a value unassigned and infers a latch.
    always_comb begin
        any_req = |req;
        winner  = PORT_A;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (!req[PORT_A] && req[PORT_B]) begin
            winner = PORT_B;
        end
`else
        if (&req) begin
            winner = ~last_winner;
        end else if (req[PORT_B]) begin
            winner = PORT_B;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory between port A (CPU load/store) and
// port B (DMA/debug loader). Each access is one ACCESS cycle with the
// memory strobes driven for the whole cycle, followed by one RESP cycle
// that returns completion and read data; RESP re-arbitrates, so back-to-back
// accesses run at one per two cycles.
// Build option: MEM_ARB_FIXED_PRIO_EN (see rr_arb2) selects fixed A-first
// priority instead of round-robin.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              winner_q;
    logic              last_winner_q;
    logic              we_q;

    logic              any_req;
    logic              arb_winner;
    logic              grant_now;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr_arb2 (
        .req         ({b_req, a_req}),
        .last_winner (last_winner_q),
        .any_req     (any_req),
        .winner      (arb_winner)
    );

    // Command fields of whichever port the arbiter is selecting right now.
    assign sel_we    = (arb_winner == PORT_A) ? a_we    : b_we;
    assign sel_addr  = (arb_winner == PORT_A) ? a_addr  : b_addr;
    assign sel_wdata = (arb_winner == PORT_A) ? a_wdata : b_wdata;

    // State register; the reset is synchronous, sampled on the clock edge.
    // NOTE: clocked state uses non-blocking (<=) so every register sees the
    // pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus all per-cycle strobes (gnt, rvalid, mem enables).
    always_comb begin
        state_d   = state_q;
        grant_now = 1'b0;
        a_gnt     = 1'b0;
        b_gnt     = 1'b0;
        a_rvalid  = 1'b0;
        b_rvalid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_now = 1'b1;
                    state_d   = ACCESS;
                end
            end
            ACCESS: begin
                a_gnt     = (winner_q == PORT_A);
                b_gnt     = (winner_q == PORT_B);
                mem_write = we_q;
                mem_read  = ~we_q;
                state_d   = RESP;
            end
            RESP: begin
                a_rvalid = (winner_q == PORT_A);
                b_rvalid = (winner_q == PORT_B);
                if (any_req) begin
                    grant_now = 1'b1;
                    state_d   = ACCESS;
                end else begin
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the granted command (held on the memory bus until the next grant)
    // and capture read data into the winning port at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            winner_q      <= PORT_A;
            last_winner_q <= PORT_B;
            we_q          <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            a_rdata       <= '0;
            b_rdata       <= '0;
        end else begin
            if (grant_now) begin
                winner_q      <= arb_winner;
                last_winner_q <= arb_winner;
                we_q          <= sel_we;
                mem_addr      <= sel_addr;
                mem_wdata     <= sel_wdata;
            end
            if (state_q == ACCESS && !we_q) begin
                if (winner_q == PORT_A) begin
                    a_rdata <= mem_rdata;
                end else begin
                    b_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a 256x8 memory model on the
// memory side, directed requester tasks on ports A and B, and a
// transaction-timeline reference model compared against every output on
// every cycle, plus literal checks on latency, grant order and read data.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_req = 1'b0, a_we = 1'b0;
    logic [7:0] a_addr = 8'h00, a_wdata = 8'h00;
    logic       a_gnt, a_rvalid;
    logic [7:0] a_rdata;

    logic       b_req = 1'b0, b_we = 1'b0;
    logic [7:0] b_addr = 8'h00, b_wdata = 8'h00;
    logic       b_gnt, b_rvalid;
    logic [7:0] b_rdata;

    logic       mem_read, mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .b_rdata   (b_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Data memory seen by the arbiter: asynchronous read, write on the edge.
    logic [7:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Timeline view: an access owns the cycle right after the edge that
    // granted it, its response owns the next cycle, and every edge not
    // closing an access may grant a waiting port.
    logic [7:0] ref_mem [256];
    logic       m_ready = 1'b0;
    logic [1:0] m_gnt, m_rvalid;
    logic [7:0] m_rdata [2];
    logic       m_mrd, m_mwr;
    logic [7:0] m_addr, m_wdata;
    logic       m_last;
    logic       m_in_access;
    logic       m_port, m_we;

    task automatic model_step();
        logic [1:0] rq;
        logic [7:0] ad [2];
        logic [7:0] wd [2];
        logic [1:0] we;
        logic       w;
        rq = {b_req, a_req};
        we = {b_we, a_we};
        ad[0] = a_addr;  ad[1] = b_addr;
        wd[0] = a_wdata; wd[1] = b_wdata;
        if (rst) begin
            m_ready = 1'b1;
            m_gnt = 2'b00; m_rvalid = 2'b00; m_mrd = 1'b0; m_mwr = 1'b0;
            m_addr = 8'h00; m_wdata = 8'h00;
            m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
            m_last = 1'b1; m_in_access = 1'b0;
        end else if (m_ready) begin
            m_gnt = 2'b00; m_rvalid = 2'b00; m_mrd = 1'b0; m_mwr = 1'b0;
            if (m_in_access) begin
                m_rvalid[m_port] = 1'b1;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_rdata[m_port] = ref_mem[m_addr];
                m_in_access = 1'b0;
            end else if (rq != 2'b00) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                w = rq[0] ? 1'b0 : 1'b1;
`else
                w = (rq == 2'b11) ? ~m_last : (rq[0] ? 1'b0 : 1'b1);
`endif
                m_gnt[w] = 1'b1;
                m_port = w; m_we = we[w];
                m_addr = ad[w]; m_wdata = wd[w];
                m_mwr = we[w]; m_mrd = ~we[w];
                m_last = w; m_in_access = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every DUT output against the model mid-cycle.
    initial forever begin
        @(negedge clk);
        if (m_ready) begin
            check("a_gnt",     a_gnt,     m_gnt[0]);
            check("b_gnt",     b_gnt,     m_gnt[1]);
            check("a_rvalid",  a_rvalid,  m_rvalid[0]);
            check("b_rvalid",  b_rvalid,  m_rvalid[1]);
            check("a_rdata",   a_rdata,   m_rdata[0]);
            check("b_rdata",   b_rdata,   m_rdata[1]);
            check("mem_read",  mem_read,  m_mrd);
            check("mem_write", mem_write, m_mwr);
            check("mem_addr",  mem_addr,  m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
        end
    end

    // Observation counters and grant-order log for the literal checks.
    int wr_cyc = 0, rd_cyc = 0, b_rv_cnt = 0;
    int gq[$];
    initial forever begin
        @(negedge clk);
        if (mem_write === 1'b1) wr_cyc++;
        if (mem_read === 1'b1)  rd_cyc++;
        if (b_rvalid === 1'b1)  b_rv_cnt++;
        if (a_gnt === 1'b1)     gq.push_back(0);
        if (b_gnt === 1'b1)     gq.push_back(1);
    end

    // ---------------- requester drivers ----------------
    task automatic set_req(input logic p, input logic r, input logic we,
                           input logic [7:0] addr, input logic [7:0] wd);
        if (p) begin
            b_req = r; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = r; a_we = we; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic port_access(input logic p, input logic we, input logic [7:0] addr,
                               input logic [7:0] wd, output int gnt_lat, output int rv_lat);
        bit ok;
        set_req(p, 1'b1, we, addr, wd);
        ok = 1'b0; gnt_lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if ((p ? b_gnt : a_gnt) === 1'b1) begin ok = 1'b1; gnt_lat = k; break; end
        end
        check(p ? "b_gnt_seen" : "a_gnt_seen", ok, 1);
        set_req(p, 1'b0, 1'b0, 8'h00, 8'h00);
        ok = 1'b0; rv_lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if ((p ? b_rvalid : a_rvalid) === 1'b1) begin ok = 1'b1; rv_lat = k; break; end
        end
        check(p ? "b_rvalid_seen" : "a_rvalid_seen", ok, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_gnt"},     a_gnt,     0);
        check({tag, "_b_gnt"},     b_gnt,     0);
        check({tag, "_a_rvalid"},  a_rvalid,  0);
        check({tag, "_b_rvalid"},  b_rvalid,  0);
        check({tag, "_mem_read"},  mem_read,  0);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_mem_addr"},  mem_addr,  0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_a_rdata"},   a_rdata,   0);
        check({tag, "_b_rdata"},   b_rdata,   0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gl, rl, w0, r0, bv0;
        int exp_seq [6];
        bit ok;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h3C;
            ref_mem[i] = 8'(i) ^ 8'h3C;
        end

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // A writes 0xA5 to 0x10: grant one cycle after request, then rvalid.
        w0 = wr_cyc; r0 = rd_cyc;
        port_access(1'b0, 1'b1, 8'h10, 8'hA5, gl, rl);
        check("a_write_gnt_lat", gl, 1);
        check("a_write_rv_lat",  rl, 1);
        check("a_write_wr_cycles", wr_cyc - w0, 1);
        check("a_write_rd_cycles", rd_cyc - r0, 0);
        check("mem_10_after_write", mem[8'h10], 8'hA5);
        check("b_rdata_after_a_write", b_rdata, 8'h00);

        // B reads back 0x10.
        w0 = wr_cyc; r0 = rd_cyc;
        port_access(1'b1, 1'b0, 8'h10, 8'h00, gl, rl);
        check("b_read_rdata", b_rdata, 8'hA5);
        check("b_read_rd_cycles", rd_cyc - r0, 1);
        check("b_read_wr_cycles", wr_cyc - w0, 0);

        // Both ports request reads continuously.
        gq.delete();
        fork
            begin : a_stream
                int g1, r1;
                for (int i = 0; i < 3; i++) port_access(1'b0, 1'b0, 8'(8'h20 + i), 8'h00, g1, r1);
            end
            begin : b_stream
                int g2, r2;
                for (int i = 0; i < 3; i++) port_access(1'b1, 1'b0, 8'(8'h30 + i), 8'h00, g2, r2);
            end
        join
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
        check("grant_count", gq.size(), 6);
        for (int i = 0; i < 6 && i < gq.size(); i++) check($sformatf("grant_order_%0d", i), gq[i], exp_seq[i]);
        check("b_last_read", b_rdata, 8'h32 ^ 8'h3C);

        // A reasserts in its rvalid cycle: next grant follows RESP directly.
        port_access(1'b0, 1'b0, 8'h40, 8'h00, gl, rl);
        port_access(1'b0, 1'b0, 8'h41, 8'h00, gl, rl);
        check("reassert_gnt_lat", gl, 1);
        check("reassert_rdata", a_rdata, 8'h41 ^ 8'h3C);

        // Reset during the ACCESS cycle of a B read.
        bv0 = b_rv_cnt;
        set_req(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (b_gnt === 1'b1) begin ok = 1'b1; break; end
        end
        check("rst_b_gnt_seen", ok, 1);
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        check("midrst_no_b_rvalid", b_rv_cnt - bv0, 0);
        port_access(1'b0, 1'b0, 8'h10, 8'h00, gl, rl);
        check("post_rst_a_gnt_lat", gl, 1);
        check("post_rst_a_rdata", a_rdata, 8'hA5);

        // Top address: write 0xFF to 0xFF, then read 0x00 and 0xFF.
        port_access(1'b0, 1'b1, 8'hFF, 8'hFF, gl, rl);
        port_access(1'b0, 1'b0, 8'h00, 8'h00, gl, rl);
        check("read_addr_00", a_rdata, 8'h3C);
        port_access(1'b0, 1'b0, 8'hFF, 8'h00, gl, rl);
        check("read_addr_ff", a_rdata, 8'hFF);

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester controller sharing the single-port 256x8 data memory between port A (CPU load/store) and port B (DMA/debug loader).
- Arbitrates requests and drives the memory's mem_read / mem_write / Address / Write_data for exactly one full clock cycle per access.
- Captures data_out and returns completion plus read data to the winning requester.
- Sits between the requesters and the data memory instance in the top level.

Parameters:
ADDR_W, 8, address width; memory depth is 2**ADDR_W.
DATA_W, 8, data width.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous active-high reset.
a_req  in  1  port A request; held with a_we/a_addr/a_wdata until a_gnt.
a_we  in  1  1 = write, 0 = read.
a_addr  in  ADDR_W  port A address.
a_wdata  in  DATA_W  port A write data.
a_gnt  out  1  one-cycle pulse: command accepted.
a_rvalid  out  1  one-cycle pulse: access complete.
a_rdata  out  DATA_W  read data, valid with a_rvalid.
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
mem_read  out  1  memory read enable.
mem_write  out  1  memory write enable.
mem_addr  out  ADDR_W  to memory Address.
mem_wdata  out  DATA_W  to memory Write_data.
mem_rdata  in  DATA_W  from memory data_out.

Behaviour:
- Clock port is clk; reset is rst, synchronous, active-high. Only one clock domain.
- Reset values:
  - State = IDLE.
  - All gnt, rvalid, mem_read and mem_write = 0.
  - mem_addr, mem_wdata, a_rdata, b_rdata = 0.
  - last_winner = B, so A wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, register the winner's we/addr/wdata, pulse that port's gnt in the next cycle, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - gnt of the winner = 1.
  - mem_addr and mem_wdata hold the latched values; they must be stable for the whole cycle because the memory samples on both edges.
  - mem_write = we and mem_read = !we.
  - At the closing edge, capture mem_rdata into the winner's rdata (reads only) and go to RESP.
- RESP (1 cycle):
  - Winner's rvalid = 1 for both reads and writes.
  - mem_read = mem_write = 0.
  - Arbitrate as in IDLE: a pending req goes to ACCESS, otherwise go to IDLE.
- Latency and throughput:
  - Request seen in IDLE at edge N: gnt is high in cycle N+1 and rvalid in cycle N+2.
  - Sustained throughput is one access per 2 cycles.
- Arbitration:
  - Round-robin between the two ports; when both request, the port not equal to last_winner wins.
  - last_winner updates when a grant is issued.
- Outside ACCESS, mem_read = mem_write = 0 and mem_addr/mem_wdata hold their last values. A write is never issued without a grant.
- A requester may drop req only after seeing gnt. Dropping req before gnt is a protocol violation and the arbiter's behaviour is unspecified.
- A requester may reassert req in the same cycle as its own rvalid; it then competes normally.
- rdata of the non-winning port is unchanged. rdata is unchanged after a write.
- Addresses outside 0..2**ADDR_W-1 cannot occur; addresses are used unsigned with no wrap logic.
- rst asserted mid-ACCESS or mid-RESP:
  - At that edge all registers clear; the pending rvalid is dropped and mem_write is 0 from the next cycle.
  - A write whose ACCESS cycle was already fully driven may have completed in memory.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: port A always wins ties and last_winner is unused (B can starve).
- Undefined (default): round-robin as above.

Decomposition:
- Shared package/include mem_arb_pkg contains:
  - State encodings: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Port IDs: PORT_A = 1'b0, PORT_B = 1'b1.
  - Default ADDR_W and DATA_W.
- One sub-module: rr_arb2.
  - Combinational two-way winner select from req[1:0] and last_winner, with the MEM_ARB_FIXED_PRIO_EN hook.
  - The FSM and datapath stay in mem_port_arbiter.

Test Plan:
- Reset, then A write addr 0x10 data 0xA5 → a_gnt in cycle 1, mem_write high for exactly 1 cycle with mem_addr 0x10, a_rvalid in cycle 2; b_* outputs stay 0.
- B read of 0x10 after that write → b_rvalid with b_rdata = 0xA5; mem_read high for exactly 1 cycle; mem_write stays 0.
- A and B both held requesting reads continuously → grants alternate A, B, A, B at 2-cycle spacing. With MEM_ARB_FIXED_PRIO_EN defined, all grants go to A.
- A reasserts req in the same cycle as its a_rvalid while B is idle → next ACCESS immediately follows RESP with no IDLE cycle.
- rst pulsed during ACCESS of a B read → b_rvalid never pulses; all outputs at reset values next cycle; a following A request completes normally.
- Write 0xFF to addr 0xFF, then read addr 0x00 and addr 0xFF → returns 0x00-region contents and 0xFF respectively; no aliasing at the top address.
